req_arbiter: RTL and testbench



---
 rtl/ctrl_types_pkg.sv | 29 ++
 rtl/rr_pick.sv | 49 ++++
 rtl/req_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_req_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_types_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_types_pkg
//   Shared types for the cache controller and the logic around it.
//   - operation_e : command encoding understood by the cache controller.
//                   NOOP doubles as "no command on the bus".
//   - arb_state_e : states of the request arbiter in front of the controller.
//   - idx_width() : bit width needed to hold an index 0..n-1 (minimum 1).
// ---------------------------------------------------------------------------
package ctrl_types_pkg;

    typedef enum logic [1:0] {
        NOOP   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        DELETE = 2'd3
    } operation_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin selector. Searches the request vector
//   starting one position after the last grant and wrapping around, and
//   returns the first requester found.
//
//   Ports:
//     req_i       [N-1:0]  request vector
//     last_i      [IW-1:0] index of the most recent grant
//     any_valid_o          at least one request bit is set
//     grant_o     [N-1:0]  one-hot grant (all zero when nothing requests)
//     idx_o       [IW-1:0] binary index of the grant (0 when nothing requests)
// ---------------------------------------------------------------------------
module rr_pick
    import ctrl_types_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          any_valid_o,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    assign any_valid_o = |req_i;

    // Candidate order is last+1, last+2, ..., last+N (mod N), so the
    // previous winner is examined last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last_i) + i) % N);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// ---------------------------------------------------------------------------
// req_arbiter
//   Shares one cache controller between NUM_REQ requesters. Round-robin
//   arbitration, one operation in flight. The granted request is latched,
//   issued to the controller as a single-cycle command, and the controller's
//   completion (or a timeout) is routed back to the originating requester.
//
//   Handshake: a requester holds valid/op/key/value until it sees its
//   req_ready_o bit (a one-cycle pulse in the accept cycle); afterwards its
//   inputs are don't-care. Exactly one resp_valid_o pulse follows per accept
//   unless reset intervenes.
//
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     req_valid_i        per-requester request valid
//     req_op_i           per-requester operation
//     req_key_i          packed keys, requester r at [r*KEY_WIDTH +: KEY_WIDTH]
//     req_value_i        packed write values, same packing
//     req_ready_o        one-hot accept pulse (combinational from req_valid_i)
//     resp_valid_o       one-hot response pulse
//     resp_succ_o        success flag, qualified by resp_valid_o
//     resp_value_o       read data, qualified by resp_valid_o
//     ctrl_op_o          controller command, NOOP except in ARB_ISSUE
//     ctrl_key_o         latched key, stable from ARB_ISSUE through ARB_RESP
//     ctrl_value_o       latched value, same hold rule
//     ctrl_rdy_i         controller completion pulse
//     ctrl_succ_i        controller success, sampled with ctrl_rdy_i
//     ctrl_value_i       controller read data, sampled with ctrl_rdy_i
//     busy_o             high whenever the arbiter is not idle
//     timeout_o          pulse in the response cycle of a timed-out operation
// ---------------------------------------------------------------------------
module req_arbiter
    import ctrl_types_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int KEY_WIDTH      = 8,
    parameter int VAL_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  operation_e [NUM_REQ-1:0]       req_op_i,
    input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key_i,
    input  logic [NUM_REQ*VAL_WIDTH-1:0]   req_value_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    output logic                           resp_succ_o,
    output logic [VAL_WIDTH-1:0]           resp_value_o,
    output operation_e                     ctrl_op_o,
    output logic [KEY_WIDTH-1:0]           ctrl_key_o,
    output logic [VAL_WIDTH-1:0]           ctrl_value_o,
    input  logic                           ctrl_rdy_i,
    input  logic                           ctrl_succ_i,
    input  logic [VAL_WIDTH-1:0]           ctrl_value_i,
    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_REQ - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    arb_state_e           state_q,  state_d;
    logic [IDX_W-1:0]     gidx_q,   gidx_d;    // owner of the operation in flight
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;  // last requester served
    operation_e           op_q,     op_d;
    logic [KEY_WIDTH-1:0] key_q,    key_d;
    logic [VAL_WIDTH-1:0] value_q,  value_d;
    logic                 succ_q,   succ_d;
    logic [VAL_WIDTH-1:0] data_q,   data_d;
    logic                 tmo_q,    tmo_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;

    // -----------------------------------------------------------------------
    // Round-robin selection
    // -----------------------------------------------------------------------
    logic               pick_any;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req_i       (req_valid_i),
        .last_i      (rr_ptr_q),
        .any_valid_o (pick_any),
        .grant_o     (pick_grant),
        .idx_o       (pick_idx)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        op_d     = op_q;
        key_d    = key_q;
        value_d  = value_q;
        succ_d   = succ_q;
        data_d   = data_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gidx_d  = pick_idx;
                    op_d    = req_op_i[pick_idx];
                    key_d   = req_key_i[int'(pick_idx) * KEY_WIDTH +: KEY_WIDTH];
                    value_d = req_value_i[int'(pick_idx) * VAL_WIDTH +: VAL_WIDTH];
                    state_d = ARB_ISSUE;
                end
            end

            ARB_ISSUE: begin
                cnt_d = '0;
                // A NOOP request is decided on the latched op: the command
                // slot drives NOOP anyway, so the controller never sees it,
                // and the requester gets an immediate failure response.
                if (op_q == NOOP) begin
                    succ_d  = 1'b0;
                    data_d  = '0;
                    state_d = ARB_RESP;
                end else begin
                    state_d = ARB_WAIT;
                end
            end

            ARB_WAIT: begin
                // ctrl_rdy_i is checked first so a completion arriving in the
                // last allowed cycle still counts as a real completion.
                if (ctrl_rdy_i) begin
                    succ_d  = ctrl_succ_i;
                    data_d  = ctrl_value_i;
                    state_d = ARB_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    succ_d  = 1'b0;
                    data_d  = '0;
                    tmo_d   = 1'b1;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ARB_RESP: begin
                tmo_d    = 1'b0;
                rr_ptr_d = gidx_q;
                state_d  = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            gidx_q   <= '0;
            rr_ptr_q <= RR_RESET;
            op_q     <= NOOP;
            key_q    <= '0;
            value_q  <= '0;
            succ_q   <= 1'b0;
            data_q   <= '0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            op_q     <= op_d;
            key_q    <= key_d;
            value_q  <= value_d;
            succ_q   <= succ_d;
            data_q   <= data_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // The accept pulse is gated by rst_n so nothing is accepted (and no
        // output toggles) while reset is held, even with requests pending.
        req_ready_o = '0;
        if (rst_n && state_q == ARB_IDLE) begin
            req_ready_o = pick_grant;
        end

        resp_valid_o = '0;
        if (state_q == ARB_RESP) begin
            resp_valid_o[gidx_q] = 1'b1;
        end
    end

    assign resp_succ_o  = succ_q;
    assign resp_value_o = data_q;
    assign ctrl_op_o    = (state_q == ARB_ISSUE) ? op_q : NOOP;
    assign ctrl_key_o   = key_q;
    assign ctrl_value_o = value_q;
    assign busy_o       = (state_q != ARB_IDLE);
    assign timeout_o    = (state_q == ARB_RESP) && tmo_q;

endmodule

// File: tb/tb_req_arbiter.sv
module tb_req_arbiter;
    import ctrl_types_pkg::*;

    localparam int N   = 4;
    localparam int KW  = 8;
    localparam int VW  = 32;
    localparam int TMO = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic [N-1:0]       req_valid = '0;
    operation_e [N-1:0] req_op;
    logic [N*KW-1:0]    req_key   = '0;
    logic [N*VW-1:0]    req_value = '0;
    logic [N-1:0]       req_ready_o;
    logic [N-1:0]       resp_valid_o;
    logic               resp_succ_o;
    logic [VW-1:0]      resp_value_o;
    operation_e         ctrl_op_o;
    logic [KW-1:0]      ctrl_key_o;
    logic [VW-1:0]      ctrl_value_o;
    logic               ctrl_rdy_i = 1'b0;
    logic               ctrl_succ_i = 1'b0;
    logic [VW-1:0]      ctrl_value_i = '0;
    logic               busy_o;
    logic               timeout_o;

    req_arbiter #(
        .NUM_REQ        (N),
        .KEY_WIDTH      (KW),
        .VAL_WIDTH      (VW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_op_i     (req_op),
        .req_key_i    (req_key),
        .req_value_i  (req_value),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_succ_o  (resp_succ_o),
        .resp_value_o (resp_value_o),
        .ctrl_op_o    (ctrl_op_o),
        .ctrl_key_o   (ctrl_key_o),
        .ctrl_value_o (ctrl_value_o),
        .ctrl_rdy_i   (ctrl_rdy_i),
        .ctrl_succ_i  (ctrl_succ_i),
        .ctrl_value_i (ctrl_value_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- controller stand-in ----------------
    // ctl_mode: 0 = answer after ctl_lat cycles, 1 = never answer, 2 = random
    int          ctl_mode   = 0;
    int          ctl_lat    = 2;
    logic        ctl_succ   = 1'b1;
    logic [VW-1:0] ctl_val  = '0;
    int          ctl_cnt    = 0;
    bit          ctl_inject = 1'b0;
    bit          spur_en    = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ctl_cnt = 0;
        end else if (ctrl_op_o != NOOP) begin
            if (ctl_mode == 0) ctl_cnt = ctl_lat;
            else if (ctl_mode == 1) ctl_cnt = 0;
            else ctl_cnt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 2);
        end
    end

    always @(posedge clk) begin
        #1;
        ctrl_rdy_i   = 1'b0;
        ctrl_succ_i  = 1'($urandom);
        ctrl_value_i = $urandom;
        if (ctl_cnt > 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                ctrl_rdy_i = 1'b1;
                if (ctl_mode == 0) begin
                    ctrl_succ_i  = ctl_succ;
                    ctrl_value_i = ctl_val;
                end
            end
        end
        if (ctl_inject) begin
            ctrl_rdy_i = 1'b1;
            ctl_inject = 1'b0;
        end else if (spur_en && ctl_cnt == 0 && $urandom_range(0, 19) == 0) begin
            ctrl_rdy_i = 1'b1;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    // The model tracks one transaction by its age in cycles since accept:
    // age 1 carries the command, the response lands one cycle after the first
    // ctrl_rdy_i seen from age 2 on, or after TMO waiting cycles with a timeout.
    bit            m_busy = 1'b0;
    int            m_last = N - 1;
    int            m_owner, m_age, m_resp_at;
    operation_e    m_op;
    logic [KW-1:0] m_key;
    logic [VW-1:0] m_val, m_rval;
    logic          m_succ, m_tmo;

    function automatic int model_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] exp_v;
        int g;
        exp_v = '0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = N - 1;
            chk("rst_ready", req_ready_o, '0);
            chk("rst_resp_valid", resp_valid_o, '0);
            chk("rst_busy", busy_o, 0);
            chk("rst_ctrl_op", ctrl_op_o, NOOP);
            chk("rst_timeout", timeout_o, 0);
            chk("rst_ctrl_key", ctrl_key_o, 0);
            chk("rst_ctrl_value", ctrl_value_o, 0);
            chk("rst_resp_succ", resp_succ_o, 0);
            chk("rst_resp_value", resp_value_o, 0);
        end else if (!m_busy) begin
            g = model_pick(req_valid, m_last);
            if (g >= 0) exp_v[g] = 1'b1;
            chk("idle_ready", req_ready_o, exp_v);
            chk("idle_busy", busy_o, 0);
            chk("idle_ctrl_op", ctrl_op_o, NOOP);
            chk("idle_resp_valid", resp_valid_o, '0);
            chk("idle_timeout", timeout_o, 0);
            if (g >= 0) begin
                m_busy    = 1'b1;
                m_owner   = g;
                m_op      = req_op[g];
                m_key     = req_key[g*KW +: KW];
                m_val     = req_value[g*VW +: VW];
                m_age     = 1;
                m_resp_at = 0;
            end
        end else begin
            chk("busy", busy_o, 1);
            chk("busy_ready", req_ready_o, '0);
            chk("ctrl_key_hold", ctrl_key_o, m_key);
            chk("ctrl_value_hold", ctrl_value_o, m_val);
            chk("ctrl_op", ctrl_op_o, (m_age == 1) ? m_op : NOOP);
            if (m_age == m_resp_at) begin
                exp_v[m_owner] = 1'b1;
                chk("resp_valid", resp_valid_o, exp_v);
                chk("resp_succ", resp_succ_o, m_succ);
                chk("resp_timeout", timeout_o, m_tmo);
                if (m_op != NOOP) chk("resp_value", resp_value_o, m_rval);
                m_busy = 1'b0;
                m_last = m_owner;
            end else begin
                chk("no_resp_valid", resp_valid_o, '0);
                chk("no_timeout", timeout_o, 0);
                if (m_resp_at == 0) begin
                    if (m_op == NOOP) begin
                        m_resp_at = 2; m_succ = 1'b0; m_tmo = 1'b0;
                    end else if (m_age >= 2) begin
                        if (ctrl_rdy_i) begin
                            m_resp_at = m_age + 1; m_succ = ctrl_succ_i;
                            m_rval = ctrl_value_i; m_tmo = 1'b0;
                        end else if (m_age == TMO + 1) begin
                            m_resp_at = m_age + 1; m_succ = 1'b0;
                            m_rval = '0; m_tmo = 1'b1;
                        end
                    end
                end
            end
            m_age++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input operation_e op,
                           input logic [KW-1:0] k, input logic [VW-1:0] v);
        req_valid[r]        = 1'b1;
        req_op[r]           = op;
        req_key[r*KW +: KW] = k;
        req_value[r*VW +: VW] = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        k = 0;
        while (busy_o && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(name, busy_o, 0);
    endtask

    task automatic wait_resp(input int max);
        int k;
        k = 0;
        while (resp_valid_o == '0 && k < max) begin
            @(negedge clk);
            k++;
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- scoreboard for grant order ----------------
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- main stimulus ----------------
    initial begin
        int t0, ncmd, nresp;
        int rcnt[N];
        logic [N-1:0] sr;

        for (int r = 0; r < N; r++) req_op[r] = NOOP;

        // ---- single READ from requester 2 ----
        do_reset();
        ctl_mode = 0; ctl_lat = 4; ctl_succ = 1'b1; ctl_val = 32'hDEADBEEF; spur_en = 1'b0;
        step();
        set_req(2, READ, 8'h15, 32'h0BADF00D);
        @(negedge clk);
        t0 = cyc;
        chk("s1_ready", req_ready_o, 4'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("s1_cmd", ctrl_op_o, READ);
        chk("s1_key", ctrl_key_o, 8'h15);
        ncmd = 0;
        for (int k = 0; k < 40 && resp_valid_o == '0; k++) begin
            @(negedge clk);
            if (ctrl_op_o != NOOP) ncmd++;
        end
        chk("s1_resp_valid", resp_valid_o, 4'b0100);
        chk("s1_resp_succ", resp_succ_o, 1);
        chk("s1_resp_value", resp_value_o, 32'hDEADBEEF);
        chk("s1_latency", cyc - t0, 6);
        chk("s1_single_cmd", ncmd, 0);
        wait_idle("s1_idle", 10);

        // ---- all four requesting continuously ----
        do_reset();
        ctl_mode = 0; ctl_lat = 2;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        got_q.delete();
        nresp = 0;
        for (int r = 0; r < N; r++) rcnt[r] = 0;
        step();
        for (int r = 0; r < N; r++) set_req(r, READ, 8'(r), 32'(r));
        for (int k = 0; k < 100 && got_q.size() < 5; k++) begin
            @(negedge clk);
            if (req_ready_o != '0) got_q.push_back(2'(onehot_idx(req_ready_o)));
            if (resp_valid_o != '0) begin
                chk("s2_onehot", 64'($onehot(resp_valid_o)), 1);
                rcnt[onehot_idx(resp_valid_o)]++;
                nresp++;
            end
        end
        step();
        req_valid = '0;
        for (int k = 0; k < 40 && busy_o; k++) begin
            @(negedge clk);
            if (resp_valid_o != '0) begin
                chk("s2_onehot", 64'($onehot(resp_valid_o)), 1);
                rcnt[onehot_idx(resp_valid_o)]++;
                nresp++;
            end
        end
        chk("s2_grant_count", got_q.size(), 5);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk("s2_grant_order", got_q.pop_front(), exp_q.pop_front());
        end
        chk("s2_resp_count", nresp, 5);
        chk("s2_resp_r0", rcnt[0], 2);
        chk("s2_resp_r3", rcnt[3], 1);
        wait_idle("s2_idle", 10);

        // ---- controller never answers: timeout ----
        ctl_mode = 1;
        step();
        set_req(1, READ, 8'h21, 32'h1);
        set_req(2, READ, 8'h22, 32'h2);
        @(negedge clk);
        t0 = cyc;
        chk("s3_ready", req_ready_o, 4'b0010);
        step();
        req_valid[1] = 1'b0;
        wait_resp(40);
        chk("s3_resp_valid", resp_valid_o, 4'b0010);
        chk("s3_latency", cyc - t0, TMO + 2);
        chk("s3_succ", resp_succ_o, 0);
        chk("s3_timeout", timeout_o, 1);
        chk("s3_value", resp_value_o, 0);
        @(negedge clk);
        chk("s3_next_grant", req_ready_o, 4'b0100);
        step();
        req_valid = '0;
        wait_idle("s3_idle", 40);

        // ---- completion in the last waiting cycle wins over timeout ----
        ctl_mode = 0; ctl_lat = TMO; ctl_succ = 1'b1; ctl_val = 32'h12345678;
        step();
        set_req(3, WRITE, 8'h33, 32'h3);
        @(negedge clk);
        t0 = cyc;
        chk("s3b_ready", req_ready_o, 4'b1000);
        step();
        req_valid = '0;
        wait_resp(40);
        chk("s3b_latency", cyc - t0, TMO + 2);
        chk("s3b_timeout", timeout_o, 0);
        chk("s3b_succ", resp_succ_o, 1);
        chk("s3b_value", resp_value_o, 32'h12345678);
        wait_idle("s3b_idle", 10);

        // ---- NOOP request ----
        ctl_mode = 0; ctl_lat = 2;
        step();
        set_req(1, NOOP, 8'h44, 32'h4);
        @(negedge clk);
        chk("s4_ready", req_ready_o, 4'b0010);
        chk("s4_op_t0", ctrl_op_o, NOOP);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("s4_op_t1", ctrl_op_o, NOOP);
        chk("s4_no_resp_t1", resp_valid_o, 4'b0000);
        @(negedge clk);
        chk("s4_resp_valid", resp_valid_o, 4'b0010);
        chk("s4_succ", resp_succ_o, 0);
        chk("s4_op_t2", ctrl_op_o, NOOP);
        wait_idle("s4_idle", 10);

        // ---- spurious ctrl_rdy_i in idle and in the command cycle ----
        ctl_mode = 0; ctl_lat = 3; ctl_succ = 1'b1; ctl_val = 32'hA5A5A5A5;
        @(negedge clk);
        ctl_inject = 1'b1;
        @(negedge clk);
        chk("s5_idle_no_resp", resp_valid_o, 4'b0000);
        chk("s5_idle_busy", busy_o, 0);
        @(negedge clk);
        chk("s5_idle_no_resp2", resp_valid_o, 4'b0000);
        step();
        set_req(3, WRITE, 8'h55, 32'h5);
        @(negedge clk);
        t0 = cyc;
        chk("s5_ready", req_ready_o, 4'b1000);
        ctl_inject = 1'b1;
        step();
        req_valid = '0;
        wait_resp(40);
        chk("s5_latency", cyc - t0, 5);
        chk("s5_succ", resp_succ_o, 1);
        wait_idle("s5_idle", 10);

        // ---- reset in the middle of a wait ----
        ctl_mode = 1;
        step();
        set_req(0, READ, 8'h66, 32'h6);
        @(negedge clk);
        chk("s6_ready", req_ready_o, 4'b0001);
        step();
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("s6_busy_wait", busy_o, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        set_req(0, READ, 8'h67, 32'h7);
        set_req(3, READ, 8'h68, 32'h8);
        @(negedge clk);
        chk("s6_rst_busy", busy_o, 0);
        chk("s6_rst_ready", req_ready_o, 4'b0000);
        chk("s6_rst_key", ctrl_key_o, 0);
        ctl_mode = 0; ctl_lat = 2;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("s6_after_rst_grant", req_ready_o, 4'b0001);
        step();
        req_valid = '0;
        wait_idle("s6_idle", 10);

        // ---- randomized traffic ----
        ctl_mode = 2;
        spur_en  = 1'b1;
        sr = '0;
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk);
            #1;
            if (c == 1200) rst_n = 1'b0;
            if (c == 1202) rst_n = 1'b1;
            for (int r = 0; r < N; r++) begin
                if (sr[r]) req_valid[r] = 1'b0;
                if (!req_valid[r]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(r, operation_e'(2'($urandom_range(0, 3))), 8'($urandom), $urandom);
                end else if ($urandom_range(0, 40) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
            @(negedge clk);
            sr = req_ready_o;
        end
        step();
        req_valid = '0;
        spur_en   = 1'b0;
        wait_idle("rand_drain", 60);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
